// File: rtl/interboard_tx.sv
// interboard_tx: serializes controller messages into 8-bit frames (MSB first)
// and sends them to the peer board over a 3-wire data/req/ack link, one
// 4-phase handshake per bit, with a per-edge ack timeout and overflow flag.
module interboard_tx #(
    parameter int SETUP_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ctrl_en,
    input  logic [2:0] ctrl_msg_type,
    input  logic [4:0] ctrl_number,
    input  logic       inter_ack,
    output logic       inter_req,
    output logic       inter_data,
    output logic       inter_ready,
    output logic       timeout_err,
    output logic       overflow_err
);

    localparam int SU_W = $clog2(SETUP_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SU_W-1:0] SU_LAST = SU_W'(SETUP_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_REQ   = 2'd2;
    localparam logic [1:0] S_REL   = 2'd3;

    logic            ack_meta_q, ack_meta_d;
    logic            ack_s_q, ack_s_d;
    logic [1:0]      state_q, state_d;
    logic [6:0]      shift_q, shift_d;     // bits still to send after inter_data
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [SU_W-1:0] su_cnt_q, su_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            req_q, req_d;
    logic            data_q, data_d;
    logic            ready_q, ready_d;
    logic            terr_q, terr_d;
    logic            oerr_q, oerr_d;
    logic            abort;

    // Next-state logic: ack synchronizer, handshake sequencing, timeout and overflow.
    always_comb begin
        ack_meta_d = inter_ack;
        ack_s_d    = ack_meta_q;
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        su_cnt_d   = su_cnt_q;
        to_cnt_d   = to_cnt_q;
        req_d      = req_q;
        data_d     = data_q;
        ready_d    = ready_q;
        terr_d     = 1'b0;
        oerr_d     = oerr_q;
        abort      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctrl_en) begin
                    data_d    = ctrl_msg_type[2];
                    shift_d   = {ctrl_msg_type[1:0], ctrl_number};
                    bit_cnt_d = 3'd0;
                    su_cnt_d  = '0;
                    to_cnt_d  = '0;
                    ready_d   = 1'b0;
                    oerr_d    = 1'b0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                // Setup time first; only after it has elapsed does a stuck-high ack count toward timeout.
                if (su_cnt_q != SU_LAST) begin
                    su_cnt_d = su_cnt_q + 1'b1;
                end else if (!ack_s_q) begin
                    req_d    = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_REQ;
                end else if (to_cnt_q == TO_LAST) begin
                    abort = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_REQ: begin
                if (ack_s_q) begin
                    req_d    = 1'b0;
                    to_cnt_d = '0;
                    state_d  = S_REL;
                end else if (to_cnt_q == TO_LAST) begin
                    abort = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: begin // S_REL
                if (!ack_s_q) begin
                    to_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        data_d    = shift_q[6];
                        shift_d   = {shift_q[5:0], 1'b0};
                        su_cnt_d  = '0;
                        state_d   = S_SETUP;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    abort = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
        endcase

        // Abandoned frame: drop the link back to idle; the message is lost.
        if (abort) begin
            req_d    = 1'b0;
            data_d   = 1'b0;
            ready_d  = 1'b1;
            terr_d   = 1'b1;
            to_cnt_d = '0;
            state_d  = S_IDLE;
        end

        // A request while busy (including on the expiry edge) is dropped and flagged.
        if (ctrl_en && (state_q != S_IDLE)) begin
            oerr_d = 1'b1;
        end
    end

    // State registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= 3'd0;
            su_cnt_q   <= '0;
            to_cnt_q   <= '0;
            req_q      <= 1'b0;
            data_q     <= 1'b0;
            ready_q    <= 1'b1;
            terr_q     <= 1'b0;
            oerr_q     <= 1'b0;
        end else begin
            ack_meta_q <= ack_meta_d;
            ack_s_q    <= ack_s_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            su_cnt_q   <= su_cnt_d;
            to_cnt_q   <= to_cnt_d;
            req_q      <= req_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            terr_q     <= terr_d;
            oerr_q     <= oerr_d;
        end
    end

    assign inter_req    = req_q;
    assign inter_data   = data_q;
    assign inter_ready  = ready_q;
    assign timeout_err  = terr_q;
    assign overflow_err = oerr_q;

endmodule

// File: tb/tb_interboard_tx.sv
// Bench for interboard_tx: a peer model answers the req/ack handshake with
// programmable delays and records inter_data at each req rise; frames are
// checked against the expected MSB-first bit order of {type, number}.
module tb_interboard_tx;

    localparam int SETUP_CYCLES   = 4;
    localparam int TIMEOUT_CYCLES = 50;

    logic       clk;
    logic       rst;
    logic       ctrl_en;
    logic [2:0] ctrl_msg_type;
    logic [4:0] ctrl_number;
    logic       inter_ack;
    logic       inter_req;
    logic       inter_data;
    logic       inter_ready;
    logic       timeout_err;
    logic       overflow_err;

    interboard_tx #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_en      (ctrl_en),
        .ctrl_msg_type(ctrl_msg_type),
        .ctrl_number  (ctrl_number),
        .inter_ack    (inter_ack),
        .inter_req    (inter_req),
        .inter_data   (inter_data),
        .inter_ready  (inter_ready),
        .timeout_err  (timeout_err),
        .overflow_err (overflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_pass  = 0;

    // Peer model controls
    bit   peer_on   = 1'b1;
    bit   peer_hold = 1'b0;
    int   ack_dly   = 3;
    int   rel_dly   = 3;
    int   pcnt;
    logic rise_q[$];

    // Link monitors
    int   stab_viol   = 0;
    int   terr_cycles = 0;
    logic prev_req    = 1'b0;
    logic prev_data   = 1'b0;

    typedef struct {
        logic [2:0] typ;
        logic [4:0] num;
        int         ad;
        int         rd;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Reference: the frame is {type, number}; the first bit on the wire is its MSB.
    function automatic logic [7:0] model_frame(input int t, input int n);
        return 8'((t * 32) + n);
    endfunction

    // Peer: ack some cycles after req rises, release some cycles after req falls.
    initial begin
        inter_ack = 1'b0;
        pcnt = 0;
        forever begin
            @(negedge clk);
            if (peer_hold) begin
                inter_ack = 1'b1;
                pcnt = 0;
            end else if (!peer_on) begin
                inter_ack = 1'b0;
                pcnt = 0;
            end else if (!inter_ack) begin
                if (inter_req) begin
                    if (pcnt == 0) rise_q.push_back(inter_data);
                    if (pcnt >= ack_dly) begin
                        inter_ack = 1'b1;
                        pcnt = 0;
                    end else pcnt++;
                end else pcnt = 0;
            end else begin
                if (!inter_req) begin
                    if (pcnt >= rel_dly) begin
                        inter_ack = 1'b0;
                        pcnt = 0;
                    end else pcnt++;
                end else pcnt = 0;
            end
        end
    end

    // Data must not move while req is high; count timeout_err high cycles.
    always @(negedge clk) begin
        if (inter_req && prev_req && (inter_data !== prev_data)) stab_viol++;
        prev_req  = inter_req;
        prev_data = inter_data;
        if (timeout_err === 1'b1) terr_cycles++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (inter_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic start_frame(input logic [2:0] t, input logic [4:0] n, input string nm);
        bit ok;
        wait_ready(3000, ok);
        check({nm, " ready_before"}, int'(ok), 1);
        rise_q.delete();
        ctrl_msg_type = t;
        ctrl_number   = n;
        ctrl_en       = 1'b1;
        @(negedge clk);
        ctrl_en = 1'b0;
        check({nm, " ready_low"}, int'(inter_ready), 0);
    endtask

    task automatic finish_frame(input logic [7:0] exp, input string nm);
        bit ok;
        logic [7:0] got;
        wait_ready(3000, ok);
        check({nm, " done"}, int'(ok), 1);
        check({nm, " nbits"}, rise_q.size(), 8);
        got = '0;
        for (int i = 0; i < rise_q.size() && i < 8; i++) got = {got[6:0], rise_q[i]};
        check({nm, " bits"}, int'(got), int'(exp));
    endtask

    initial begin
        int  n;
        int  t0;
        bit  seen_req;
        int  rt, rn;

        vecs[0] = '{3'b011, 5'd17, 3, 3, 8'h71};
        vecs[1] = '{3'b000, 5'd0,  1, 1, 8'h00};
        vecs[2] = '{3'b111, 5'd31, 2, 5, 8'hFF};
        vecs[3] = '{3'b101, 5'd10, 4, 2, 8'hAA};
        vecs[4] = '{3'b010, 5'd21, 0, 0, 8'h55};

        rst = 1'b1;
        ctrl_en = 1'b0;
        ctrl_msg_type = '0;
        ctrl_number = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset ready", int'(inter_ready), 1);
        check("reset req", int'(inter_req), 0);
        check("reset data", int'(inter_data), 0);
        check("reset timeout_err", int'(timeout_err), 0);
        check("reset overflow_err", int'(overflow_err), 0);

        // Fixed vectors
        for (int i = 0; i < 5; i++) begin
            ack_dly = vecs[i].ad;
            rel_dly = vecs[i].rd;
            start_frame(vecs[i].typ, vecs[i].num, $sformatf("vec%0d", i));
            finish_frame(vecs[i].exp, $sformatf("vec%0d", i));
        end
        check("vec no_timeout", terr_cycles, 0);

        // Overflow: second request 10 cycles into a frame
        ack_dly = 3;
        rel_dly = 3;
        start_frame(3'b001, 5'd9, "ovf");
        repeat (9) @(negedge clk);
        ctrl_msg_type = 3'b111;
        ctrl_number   = 5'd31;
        ctrl_en       = 1'b1;
        @(negedge clk);
        ctrl_en = 1'b0;
        check("ovf flag", int'(overflow_err), 1);
        finish_frame(model_frame(1, 9), "ovf");
        repeat (100) @(negedge clk);
        check("ovf no_extra_frame", rise_q.size(), 8);
        check("ovf still_idle", int'(inter_ready), 1);
        check("ovf sticky", int'(overflow_err), 1);
        start_frame(3'b100, 5'd2, "ovf_clr");
        check("ovf cleared", int'(overflow_err), 0);
        finish_frame(model_frame(4, 2), "ovf_clr");

        // Timeout: peer never acks
        peer_on = 1'b0;
        t0 = terr_cycles;
        start_frame(3'b110, 5'd3, "to");
        n = 0;
        while (!inter_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("to req_rise", int'(inter_req), 1);
        n = 0;
        while (inter_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("to req_high_cycles", n, TIMEOUT_CYCLES);
        check("to ready", int'(inter_ready), 1);
        check("to err_pulse", int'(timeout_err), 1);
        check("to data", int'(inter_data), 0);
        @(negedge clk);
        check("to err_clear", int'(timeout_err), 0);
        repeat (5) @(negedge clk);
        check("to err_cycles", terr_cycles - t0, 1);
        peer_on = 1'b1;
        start_frame(3'b110, 5'd3, "to_after");
        finish_frame(model_frame(6, 3), "to_after");

        // Ack stuck high at request, then released
        rel_dly = 2;
        peer_hold = 1'b1;
        repeat (3) @(negedge clk);
        start_frame(3'b011, 5'd6, "hold");
        seen_req = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (inter_req) seen_req = 1'b1;
        end
        check("hold req_low", int'(seen_req), 0);
        peer_hold = 1'b0;
        finish_frame(model_frame(3, 6), "hold");

        // Ack stuck high forever: timeout without req ever rising
        t0 = terr_cycles;
        peer_hold = 1'b1;
        repeat (3) @(negedge clk);
        start_frame(3'b001, 5'd1, "hold_to");
        seen_req = 1'b0;
        n = 0;
        while (!inter_ready && n < 300) begin
            @(negedge clk);
            if (inter_req) seen_req = 1'b1;
            n++;
        end
        check("hold_to req_low", int'(seen_req), 0);
        check("hold_to ready", int'(inter_ready), 1);
        repeat (3) @(negedge clk);
        check("hold_to err_cycles", terr_cycles - t0, 1);
        peer_hold = 1'b0;
        repeat (10) @(negedge clk);

        // Reset while req is high on the fourth bit
        ack_dly = 6;
        rel_dly = 1;
        start_frame(3'b101, 5'd12, "rst");
        n = 0;
        while (!(rise_q.size() == 4 && inter_req) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rst reach_bit4", rise_q.size(), 4);
        check("rst req_high", int'(inter_req), 1);
        rst = 1'b1;
        peer_on = 1'b0;
        @(negedge clk);
        check("rst req", int'(inter_req), 0);
        check("rst ready", int'(inter_ready), 1);
        check("rst data", int'(inter_data), 0);
        rst = 1'b0;
        peer_on = 1'b1;
        ack_dly = 2;
        start_frame(3'b101, 5'd12, "rst_new");
        finish_frame(model_frame(5, 12), "rst_new");

        // Randomized frames against the reference model
        for (int i = 0; i < 12; i++) begin
            rt = int'($urandom_range(0, 7));
            rn = int'($urandom_range(0, 31));
            ack_dly = int'($urandom_range(0, 6));
            rel_dly = int'($urandom_range(0, 6));
            start_frame(3'(rt), 5'(rn), $sformatf("rnd%0d", i));
            finish_frame(model_frame(rt, rn), $sformatf("rnd%0d", i));
        end

        repeat (5) @(negedge clk);
        check("data_stable_under_req", stab_viol, 0);
        check("total_timeout_cycles", terr_cycles, 2);
        check("final overflow_err", int'(overflow_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/interboard_tx.md
Name: interboard_tx

Overview:
- Downstream of the slave game controller; receives its one-cycle message strobe (ctrl_en, ctrl_msg_type, ctrl_number).
- Serializes each message as an 8-bit frame to the peer board over a 3-wire bit-serial link: data, req and ack.
- Each bit uses a 4-phase req/ack handshake.
- Returns inter_ready to the controller. The controller holds its SEND_* states until inter_ready is high.

Parameters:
- SETUP_CYCLES, 4: cycles inter_data is held stable before inter_req rises, per bit (min 1).
- TIMEOUT_CYCLES, 1000000: max cycles waiting for any single ack edge before the frame is abandoned.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- ctrl_en  in  1  one-cycle request to send a frame.
- ctrl_msg_type  in  3  message type, captured with ctrl_en.
- ctrl_number  in  5  number field, captured with ctrl_en.
- inter_ack  in  1  peer acknowledge; asynchronous to clk.
- inter_req  out  1  request strobe to peer, registered.
- inter_data  out  1  serial data to peer, registered.
- inter_ready  out  1  high = idle and able to accept ctrl_en, registered.
- timeout_err  out  1  one-cycle pulse when a frame is abandoned.
- overflow_err  out  1  sticky; set when ctrl_en arrives while busy.

Behaviour:
- Reset values: inter_req=0, inter_data=0, inter_ready=1, timeout_err=0, overflow_err=0, state=IDLE, bit_cnt=0, shift register=0, all counters=0.
- rst aborts any frame immediately, including one mid-handshake.
- inter_ack passes through a 2-FF synchronizer (ack_s) before any use.
- Frame format: {ctrl_msg_type, ctrl_number}, 8 bits, sent MSB first. No parity, no start bit.
- IDLE:
  - ctrl_en=1 loads the shift register, clears bit_cnt and the cycle counter, drives inter_data=frame[7], and goes to SETUP.
  - inter_ready falls on that same edge, so it reads 0 in the cycle after ctrl_en.
- SETUP:
  - Hold inter_data.
  - Count SETUP_CYCLES cycles and also require ack_s=0, then go to REQ and set inter_req=1.
  - If ack_s stays 1, this wait is covered by the timeout.
- REQ:
  - Wait for ack_s=1, then set inter_req=0 and go to REL.
- REL:
  - Wait for ack_s=0.
  - If bit_cnt=7, go to IDLE and set inter_ready=1.
  - Otherwise increment bit_cnt, shift so inter_data takes the next bit, clear the cycle counter, and go to SETUP.
- inter_data changes only in the REL→SETUP transition or at IDLE load. It never changes while inter_req=1.
- Timeout:
  - One counter, cleared on every state entry, counts in SETUP (ack-wait part only), REQ and REL.
  - On reaching TIMEOUT_CYCLES-1: inter_req=0, inter_data=0, state=IDLE, inter_ready=1, and timeout_err=1 for exactly one cycle.
  - The game controller treats this as completion; the message is lost.
- Overflow: ctrl_en while state≠IDLE is ignored. The frame in flight is unaffected and overflow_err is set.
- overflow_err is cleared by rst, or by the next ctrl_en accepted in IDLE.
- Simultaneous ctrl_en and timeout expiry: the expiry takes the edge, the ctrl_en counts as overflow, and the new frame is not accepted.
- Minimum frame time with an instant peer is about 8×(SETUP_CYCLES+4+synchronizer latency) cycles.
- Back-to-back: ctrl_en in the first cycle inter_ready=1 is accepted normally.

Test Plan:
- Reset then idle, with inter_ack=0: inter_ready=1, inter_req=0, inter_data=0, both error outputs 0.
- ctrl_en with type=3'b011 and number=5'd17, peer model acks 3 cycles after req and releases 3 cycles after req drops:
  - inter_data samples at each req rise read 0,1,1,1,0,0,0,1.
  - inter_ready=0 the cycle after ctrl_en and returns to 1 after the 8th ack release.
  - Bit 0 must not change while req=1.
- Second ctrl_en pulse 10 cycles into a frame: overflow_err=1, the original frame completes unchanged, no extra frame is sent. The next accepted ctrl_en clears overflow_err.
- TIMEOUT_CYCLES=50, peer never acks:
  - req rises, and 50 cycles later req=0, inter_ready=1, and timeout_err pulses high for exactly 1 cycle.
  - A following frame completes normally.
- inter_ack held high at ctrl_en: inter_req stays 0 until ack_s falls. With ack never falling, timeout_err fires.
- rst asserted while inter_req=1 at bit 4: next cycle inter_req=0, inter_ready=1, and a new frame starts again from bit 7.
